// File: rtl/spi_slave_if.sv
// spi_slave_if: serial front end of the SPI memory slave.
// Deserializes MOSI command frames and serializes read data on MISO.
module spi_slave_if #(
  parameter int MEM_DEPTH = 256,
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH),
  localparam int N = ADDR_SIZE + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [N-1:0]         rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int CW = $clog2(N) + 1;
  localparam int TW = $clog2(ADDR_SIZE) + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    TX_WAIT1 = 3'd2,
    TX_WAIT2 = 3'd3,
    SEND     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        bit_cnt;
  logic [TW-1:0]        tx_cnt;
  logic [N-2:0]         rx_shift;
  logic [ADDR_SIZE-1:0] tx_shift;
  logic                 rx_last;
  logic                 tx_last;
  logic                 is_read;
  logic                 abort;

  assign rx_last = (bit_cnt == CW'(N - 1));
  assign tx_last = (tx_cnt == TW'(ADDR_SIZE));
  assign is_read = (rx_shift[N-2 -: 2] == 2'b11);
  assign abort   = (state != IDLE) && SS_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:     if (!SS_n) state_nx = RECV;
        RECV:     if (rx_last) state_nx = is_read ? TX_WAIT1 : DONE;
        TX_WAIT1: state_nx = TX_WAIT2;
        TX_WAIT2: if (tx_valid) state_nx = SEND;
        SEND:     if (tx_last) state_nx = DONE;
        DONE:     state_nx = DONE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  // tx_cnt counts MISO bits already driven in the current read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MISO     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      bit_cnt  <= '0;
      tx_cnt   <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        MISO <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            MISO     <= 1'b0;
            bit_cnt  <= '0;
            tx_cnt   <= '0;
            rx_shift <= '0;
          end
          RECV: begin
            rx_shift <= {rx_shift[N-3:0], MOSI};
            bit_cnt  <= bit_cnt + 1'b1;
            if (rx_last) begin
              rx_data  <= {rx_shift, MOSI};
              rx_valid <= 1'b1;
            end
          end
          TX_WAIT2: begin
            if (tx_valid) begin
              tx_shift <= tx_data;
              MISO     <= tx_data[ADDR_SIZE-1];
              tx_cnt   <= TW'(1);
            end
          end
          SEND: begin
            if (tx_last) begin
              MISO <= 1'b0;
            end else begin
              MISO     <= tx_shift[ADDR_SIZE-2];
              tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
              tx_cnt   <= tx_cnt + 1'b1;
            end
          end
          default: MISO <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front end of the SPI memory slave. Deserializes MOSI command frames of `ADDR_SIZE+2` bits into `rx_data`/`rx_valid` for the memory core. For read-data commands (opcode `11`), it captures the core's `tx_data` and serializes it MSB-first on MISO. The block uses a single system clock, which also acts as the SPI bit clock.

## Interface

**Parameters**
- `MEM_DEPTH`, default 256: memory depth. Local `ADDR_SIZE = $clog2(MEM_DEPTH)`, and frame length `N = ADDR_SIZE+2`.

**Ports**
- `clk`  in  1  system/SPI bit clock; all logic on the posedge.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `SS_n`  in  1  slave select, active-low; frame boundary.
- `MOSI`  in  1  serial command/data in, MSB first.
- `MISO`  out  1  serial read data out, MSB first; registered.
- `rx_data`  out  N  last complete frame: `{opcode[1:0], payload[ADDR_SIZE-1:0]}`.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` is updated.
- `tx_data`  in  ADDR_SIZE  read data from the memory core.
- `tx_valid`  in  1  `tx_data` valid. It is level-held by the core until its next `rx_valid`.

## Operation

**Reset**
- When `rst_n`=0 at a posedge: state IDLE; `MISO`=0, `rx_data`=0, `rx_valid`=0; shift registers and counters cleared.
- Reset overrides all other inputs, including mid-frame and mid-SEND.

**States:** IDLE, RECV, TX_WAIT1, TX_WAIT2, SEND, DONE.

- **IDLE**
  - `SS_n`=0 → RECV, bit count = 0.
  - MOSI is not sampled on this edge.
- **RECV**
  - Each edge shifts MOSI in; count increments.
  - On the N-th sample: `rx_data <= {shift[N-2:0], MOSI}`, `rx_valid <= 1`.
  - Next state: TX_WAIT1 if the opcode (the first two bits received) is `11`, else DONE.
- **TX_WAIT1**
  - Unconditionally → TX_WAIT2.
  - This cycle exists so that a stale `tx_valid` from a previous read is never sampled: the core updates `tx_data`/`tx_valid` on the edge after `rx_valid`.
- **TX_WAIT2**
  - `tx_valid`=1 → load the tx shift register with `tx_data`, `MISO <= tx_data[ADDR_SIZE-1]`, → SEND.
  - Otherwise stay.
- **SEND**
  - Each edge drives the next lower bit onto MISO.
  - After the LSB has been driven for one cycle: `MISO <= 0` → DONE.
- **DONE**
  - Further MOSI bits are ignored and no `rx_valid` is generated. Wait for `SS_n`=1.

**Global rules**
- `SS_n`=1 sampled in any non-IDLE state → IDLE on that edge; `MISO <= 0`, `rx_valid <= 0`.
- A partial frame is discarded: `rx_data` is unchanged and no pulse is generated.
- `rx_valid` is cleared on the edge after it is set.
- `rx_data` holds its value until the next complete frame.
- `MISO` is 0 in every state except SEND (and the TX_WAIT2 load edge).
- Opcodes `00`, `01`, `10` produce no MISO activity.
- Bit counter width is `$clog2(N)+1`; it never wraps within a frame.

## Timing

**Receive path** (E0 is the edge where IDLE samples `SS_n`=0)
- Frame bit *i* (i = 0 is MSB) must be stable before edge E(i+1).
- The last bit is sampled at EN; `rx_valid` is high from EN to EN+1.
- RAM latency: for a write-class frame, the core acts at EN+1.

**Read path** (opcode `11`)
- EN+1 → TX_WAIT2.
- With the standard core, `tx_valid` is high at EN+2, so the load occurs at EN+2 and `MISO` = `tx_data[MSB]` from EN+2.
- Bit `ADDR_SIZE-1-k` is driven from EN+2+k.
- `MISO` returns to 0 at EN+2+ADDR_SIZE.
- Minimum `SS_n` low time for a read frame: 1 + N + 2 + ADDR_SIZE edges (21 for the default).

**Frame spacing**
- `SS_n` high for a single cycle is sufficient between frames.

## Test plan

All values below use the default, `MEM_DEPTH`=256.

1. **Write address.** Reset; `SS_n` low; shift `00_0011_1100`.
   - Required: `rx_data`=0x03C, with `rx_valid` high exactly one cycle at E10; `MISO` stays 0.
2. **Write data, then read back.**
   - Shift `01_1010_0101`: `rx_data`=0x1A5.
   - Then `10_0011_1100`, then `11_xxxx_xxxx` with the memory core attached.
   - Required: MISO carries 0xA5 MSB-first, bits driven from E12 to E19, then 0.
3. **Back-to-back reads.** Two reads of different addresses holding 0xA5 and 0x5A, where `tx_valid` is still 1 from the first read.
   - Required: the second MISO stream is 0x5A, never a stale 0xA5.
4. **Abort.** Raise `SS_n` after 6 bits of a frame, then send a full `00_1111_0000`.
   - Required: no `rx_valid` for the aborted frame; `rx_data` updates only to 0x0F0.
5. **Reset mid-SEND.** Assert `rst_n`=0 at the 3rd MISO bit.
   - Required: next edge `MISO`=0, `rx_data`=0, state IDLE.
   - A fresh frame after reset is received correctly.
6. **Extra bits after a write frame.** Keep `SS_n` low and toggle MOSI for 15 more cycles.
   - Required: no second `rx_valid`; `MISO`=0 throughout.
